// File: rtl/loop_limit_pkg.sv
// rtl/loop_limit_pkg.sv - shared state encodings, mode constants and helpers for loop_limit_multi
package loop_limit_pkg;

  typedef enum logic [1:0] {
    LL_IDLE = 2'd0,
    LL_RUN  = 2'd1,
    LL_DONE = 2'd2,
    LL_FAIL = 2'd3
  } ll_state_e;

  localparam int LL_MODE_STICKY = 0;
  localparam int LL_MODE_REARM  = 1;

  // Adds a per-cycle fail-entry count to the 8-bit total, pinning at 255.
  function automatic logic [7:0] ll_sat_add(input logic [7:0] total, input logic [4:0] incr);
    logic [8:0] sum;
    sum = {1'b0, total} + {4'b0000, incr};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/loop_limit_chan.sv
// rtl/loop_limit_chan.sv - one loop-limit channel: IDLE/RUN/DONE/FAIL FSM plus bounded iteration counter
module loop_limit_chan
  import loop_limit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LIMIT = 5000,
  parameter int MODE  = LL_MODE_STICKY
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             stop_i,
  input  logic             clear_fail_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic             fail_enter_o
);

  localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

  ll_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             fail_enter_q, fail_enter_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= LL_IDLE;
      count_q      <= '0;
      fail_enter_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fail_enter_q <= fail_enter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      LL_IDLE: begin
        if (start_i) begin
          state_d = LL_RUN;
          count_d = '0;
        end
      end
      LL_RUN: begin
        // start shadows step/stop; an overflowing step shadows stop
        if (start_i) begin
          count_d = '0;
        end else if (step_i && (count_q == LIMIT_C)) begin
          state_d = LL_FAIL;
        end else begin
          if (step_i) count_d = count_q + 1'b1;
          if (stop_i) state_d = LL_DONE;
        end
      end
      LL_DONE: begin
        if (start_i) begin
          state_d = LL_RUN;
          count_d = '0;
        end else begin
          state_d = LL_IDLE;
        end
      end
      LL_FAIL: begin
        if (MODE == LL_MODE_REARM) state_d = LL_IDLE;
        else if (clear_fail_i)     state_d = LL_IDLE;
      end
      default: state_d = LL_IDLE;
    endcase
  end

  // Registered so the shared fail counter moves in step with fail_any
  assign fail_enter_d = (state_d == LL_FAIL) && (state_q != LL_FAIL);

  assign count_o      = count_q;
  assign busy_o       = (state_q == LL_RUN);
  assign done_o       = (state_q == LL_DONE);
  assign fail_o       = (state_q == LL_FAIL);
  assign fail_enter_o = fail_enter_q;

endmodule

// File: rtl/loop_limit_multi.sv
// rtl/loop_limit_multi.sv - CHANNELS independent loop-limit checkers with packed count bus,
// registered fail_any and a saturating fail entry counter.
module loop_limit_multi
  import loop_limit_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int LIMIT    = 5000,
  parameter int MODE     = LL_MODE_STICKY
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [CHANNELS-1:0]       start_i,
  input  logic [CHANNELS-1:0]       step_i,
  input  logic [CHANNELS-1:0]       stop_i,
  input  logic                      clear_fail_i,
  output logic [CHANNELS*WIDTH-1:0] current_loop_actualize_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS-1:0]       done_o,
  output logic [CHANNELS-1:0]       fail_o,
  output logic                      fail_any_o,
  output logic [7:0]                fail_count_o
);

  logic [CHANNELS-1:0] fail_enter;
  logic [4:0]          n_enter;
  logic                fail_any_q, fail_any_d;
  logic [7:0]          fail_count_q, fail_count_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    loop_limit_chan #(
      .WIDTH (WIDTH),
      .LIMIT (LIMIT),
      .MODE  (MODE)
    ) u_chan (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .start_i      (start_i[i]),
      .step_i       (step_i[i]),
      .stop_i       (stop_i[i]),
      .clear_fail_i (clear_fail_i),
      .count_o      (current_loop_actualize_o[i*WIDTH +: WIDTH]),
      .busy_o       (busy_o[i]),
      .done_o       (done_o[i]),
      .fail_o       (fail_o[i]),
      .fail_enter_o (fail_enter[i])
    );
  end

  always_comb begin
    n_enter = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      n_enter = n_enter + {4'b0000, fail_enter[i]};
    end
  end

  assign fail_any_d   = |fail_o;
  assign fail_count_d = ll_sat_add(fail_count_q, n_enter);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fail_any_q   <= 1'b0;
      fail_count_q <= '0;
    end else begin
      fail_any_q   <= fail_any_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign fail_any_o   = fail_any_q;
  assign fail_count_o = fail_count_q;

endmodule

// File: tb/tb_loop_limit_multi.sv
// tb/tb_loop_limit_multi.sv - directed bench for loop_limit_multi: sticky instance (a) and auto-rearm instance (b)
module tb_loop_limit_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  start_a = '0, step_a = '0, stop_a = '0;
  logic        clear_a = 1'b0;
  logic [3:0]  start_b = '0, step_b = '0, stop_b = '0;
  logic        clear_b = 1'b0;

  logic [63:0] cnt_a, cnt_b;
  logic [3:0]  busy_a, done_a, fail_a, busy_b, done_b, fail_b;
  logic        fany_a, fany_b;
  logic [7:0]  fcnt_a, fcnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  loop_limit_multi #(.CHANNELS(4), .WIDTH(16), .LIMIT(5000), .MODE(0)) dut_a (
    .clk_i(clk), .reset_i(reset), .start_i(start_a), .step_i(step_a), .stop_i(stop_a),
    .clear_fail_i(clear_a), .current_loop_actualize_o(cnt_a), .busy_o(busy_a),
    .done_o(done_a), .fail_o(fail_a), .fail_any_o(fany_a), .fail_count_o(fcnt_a)
  );

  loop_limit_multi #(.CHANNELS(4), .WIDTH(16), .LIMIT(5000), .MODE(1)) dut_b (
    .clk_i(clk), .reset_i(reset), .start_i(start_b), .step_i(step_b), .stop_i(stop_b),
    .clear_fail_i(clear_b), .current_loop_actualize_o(cnt_b), .busy_o(busy_b),
    .done_o(done_b), .fail_o(fail_b), .fail_any_o(fany_b), .fail_count_o(fcnt_b)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    tick(2);
    chk("rst_cnt",   cnt_a, 64'h0);
    chk("rst_busy",  {60'h0, busy_a}, 64'h0);
    chk("rst_done",  {60'h0, done_a}, 64'h0);
    chk("rst_fail",  {60'h0, fail_a}, 64'h0);
    chk("rst_fany",  {63'h0, fany_a}, 64'h0);
    chk("rst_fcnt",  {56'h0, fcnt_a}, 64'h0);
    reset = 1'b0;
    tick();

    // ch0: 4999 steps then stop -> done pulse, count 4999
    start_a[0] = 1'b1; tick(); start_a[0] = 1'b0;
    chk("c0_busy", {63'h0, busy_a[0]}, 64'h1);
    chk("c0_cnt0", {48'h0, cnt_a[15:0]}, 64'd0);
    step_a[0] = 1'b1; tick(4999); step_a[0] = 1'b0;
    chk("c0_cnt4999", {48'h0, cnt_a[15:0]}, 64'd4999);
    stop_a[0] = 1'b1; tick(); stop_a[0] = 1'b0;
    chk("c0_done",   {63'h0, done_a[0]}, 64'h1);
    chk("c0_notbusy", {63'h0, busy_a[0]}, 64'h0);
    chk("c0_donecnt", {48'h0, cnt_a[15:0]}, 64'd4999);
    chk("c0_nofail", {60'h0, fail_a}, 64'h0);
    tick();
    chk("c0_done_1cyc", {63'h0, done_a[0]}, 64'h0);
    chk("c0_holdcnt", {48'h0, cnt_a[15:0]}, 64'd4999);

    // ch1: 5001 steps -> FAIL on the 5001st, count pinned at LIMIT
    start_a[1] = 1'b1; tick(); start_a[1] = 1'b0;
    step_a[1] = 1'b1; tick(5000);
    chk("c1_atlimit", {48'h0, cnt_a[31:16]}, 64'd5000);
    chk("c1_busy_at_limit", {63'h0, busy_a[1]}, 64'h1);
    tick(); step_a[1] = 1'b0;
    chk("c1_fail",    {63'h0, fail_a[1]}, 64'h1);
    chk("c1_cnt_lim", {48'h0, cnt_a[31:16]}, 64'd5000);
    chk("c1_fany_lag", {63'h0, fany_a}, 64'h0);
    chk("c1_fcnt_lag", {56'h0, fcnt_a}, 64'd0);
    tick();
    chk("c1_fany",  {63'h0, fany_a}, 64'h1);
    chk("c1_fcnt1", {56'h0, fcnt_a}, 64'd1);

    // sticky: start ignored, clear_fail returns to IDLE
    start_a[1] = 1'b1; tick(); start_a[1] = 1'b0;
    chk("c1_start_ign_fail", {63'h0, fail_a[1]}, 64'h1);
    chk("c1_start_ign_busy", {63'h0, busy_a[1]}, 64'h0);
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    chk("c1_cleared", {63'h0, fail_a[1]}, 64'h0);
    chk("c1_idle",    {63'h0, busy_a[1]}, 64'h0);
    chk("c1_cnt_hold", {48'h0, cnt_a[31:16]}, 64'd5000);
    tick();
    chk("c1_fany_clr", {63'h0, fany_a}, 64'h0);
    chk("c1_fcnt_keep", {56'h0, fcnt_a}, 64'd1);

    // ch2: at LIMIT, step+stop together -> FAIL wins, no done
    start_a[2] = 1'b1; tick(); start_a[2] = 1'b0;
    step_a[2] = 1'b1; tick(5000);
    stop_a[2] = 1'b1; tick(); step_a[2] = 1'b0; stop_a[2] = 1'b0;
    chk("c2_fail_wins", {63'h0, fail_a[2]}, 64'h1);
    chk("c2_no_done",   {63'h0, done_a[2]}, 64'h0);
    tick();
    chk("c2_fcnt2", {56'h0, fcnt_a}, 64'd2);
    // clear_fail and start together -> IDLE, start not honoured
    clear_a = 1'b1; start_a[2] = 1'b1; tick(); clear_a = 1'b0; start_a[2] = 1'b0;
    chk("c2_clr_start_fail", {63'h0, fail_a[2]}, 64'h0);
    chk("c2_clr_start_busy", {63'h0, busy_a[2]}, 64'h0);
    tick();
    chk("c2_still_idle", {63'h0, busy_a[2]}, 64'h0);

    // ch3: count 10, start+step together -> count 0, still RUN
    start_a[3] = 1'b1; tick(); start_a[3] = 1'b0;
    step_a[3] = 1'b1; tick(10); step_a[3] = 1'b0;
    chk("c3_cnt10", {48'h0, cnt_a[63:48]}, 64'd10);
    start_a[3] = 1'b1; step_a[3] = 1'b1; tick(); start_a[3] = 1'b0; step_a[3] = 1'b0;
    chk("c3_restart_cnt", {48'h0, cnt_a[63:48]}, 64'd0);
    chk("c3_restart_busy", {63'h0, busy_a[3]}, 64'h1);
    step_a[3] = 1'b1; stop_a[3] = 1'b1; tick(); step_a[3] = 1'b0; stop_a[3] = 1'b0;
    chk("c3_stepstop_done", {63'h0, done_a[3]}, 64'h1);
    chk("c3_stepstop_cnt",  {48'h0, cnt_a[63:48]}, 64'd1);
    tick();

    // all channels at 100/200/300/400, then reset mid-run
    start_a = 4'b1111; tick(); start_a = 4'b0000;
    step_a = 4'b1111; tick(100);
    step_a = 4'b1110; tick(100);
    step_a = 4'b1100; tick(100);
    step_a = 4'b1000; tick(100);
    step_a = 4'b0000;
    chk("mr_counts", cnt_a, {16'd400, 16'd300, 16'd200, 16'd100});
    chk("mr_busy",   {60'h0, busy_a}, 64'hF);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mr_cnt0",   cnt_a, 64'h0);
    chk("mr_busy0",  {60'h0, busy_a}, 64'h0);
    chk("mr_nodone", {60'h0, done_a}, 64'h0);
    chk("mr_nofail", {60'h0, fail_a}, 64'h0);
    chk("mr_fcnt0",  {56'h0, fcnt_a}, 64'd0);
    tick();
    chk("mr_nodone2", {60'h0, done_a}, 64'h0);

    // two channels overflow on the same edge
    start_a = 4'b0011; tick(); start_a = 4'b0000;
    step_a = 4'b0011; tick(5001); step_a = 4'b0000;
    chk("dual_fail", {60'h0, fail_a}, 64'h3);
    tick();
    chk("dual_fcnt", {56'h0, fcnt_a}, 64'd2);
    chk("dual_fany", {63'h0, fany_a}, 64'h1);

    // auto-rearm instance: fail for exactly one cycle, then IDLE
    start_b[0] = 1'b1; tick(); start_b[0] = 1'b0;
    step_b[0] = 1'b1; tick(5001); step_b[0] = 1'b0;
    chk("rearm_fail",  {63'h0, fail_b[0]}, 64'h1);
    chk("rearm_cnt",   {48'h0, cnt_b[15:0]}, 64'd5000);
    tick();
    chk("rearm_fail_1cyc", {63'h0, fail_b[0]}, 64'h0);
    chk("rearm_idle",  {63'h0, busy_b[0]}, 64'h0);
    chk("rearm_fcnt",  {56'h0, fcnt_b}, 64'd1);
    chk("rearm_fany",  {63'h0, fany_b}, 64'h1);
    tick();
    chk("rearm_fany_off", {63'h0, fany_b}, 64'h0);
    start_b[0] = 1'b1; tick(); start_b[0] = 1'b0;
    chk("rearm_restart", {63'h0, busy_b[0]}, 64'h1);
    chk("rearm_restart_cnt", {48'h0, cnt_b[15:0]}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
